// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a self-clearing storage array.
// Reads are combinational and can forward same-cycle write data. On a tie, the
// highest-index write port wins. A clear engine walks every entry after reset or
// on request, writing zero, before the file reports ready.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NR*AW-1:0]     rs_addr,
  output logic [NR*XLEN-1:0]   rd_data,
  input  logic [NW-1:0]        we,
  input  logic [NW*AW-1:0]     wa,
  input  logic [NW*XLEN-1:0]   wd,
  input  logic                 clear_req,
  output logic                 ready
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_e              state_q, state_d;
  logic [AW-1:0]       clr_cnt_q, clr_cnt_d;
  logic [XLEN-1:0]     mem_q [NREGS];

  logic [AW-1:0]       rdAddr;
  logic [XLEN-1:0]     rdVal;

  // State and clear-counter registers; reset restarts the clear sequence from entry 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state logic: walk every entry while clearing, re-enter CLEAR on request when ready.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = READY;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      READY: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  assign ready = (state_q == READY);

  // Storage update: the clear engine owns the array while clearing, otherwise the write
  // ports update it in ascending order so the highest-index port wins on a shared address.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (we[j] && !((ZERO_REG != 0) && (wa[j*AW +: AW] == '0))) begin
          mem_q[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Combinational read ports, with optional forwarding from matching enabled writes
  // (highest index wins), a forced-zero entry 0, and all-zero output while not ready.
  always_comb begin
    rd_data = '0;
    rdAddr  = '0;
    rdVal   = '0;
    for (int k = 0; k < NR; k++) begin
      rdAddr = rs_addr[k*AW +: AW];
      rdVal  = mem_q[rdAddr];
      if (BYPASS != 0) begin
        for (int j = 0; j < NW; j++) begin
          if (we[j] && (wa[j*AW +: AW] == rdAddr)) begin
            rdVal = wd[j*XLEN +: XLEN];
          end
        end
      end
      if ((ZERO_REG != 0) && (rdAddr == '0)) begin
        rdVal = '0;
      end
      if (!ready) begin
        rdVal = '0;
      end
      rd_data[k*XLEN +: XLEN] = rdVal;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp.
// The main instance has two write ports, bypass and a hardwired zero register.
// A second single-port instance has bypass and zero-register disabled.
module tb_regfile_mp;

  logic        clk;
  logic        rstn;

  logic [9:0]  rsAddr;
  logic [63:0] rdData;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic        clearReq;
  logic        ready;

  logic [4:0]  nbRsAddr;
  logic [31:0] nbRdData;
  logic [0:0]  nbWe;
  logic [4:0]  nbWa;
  logic [31:0] nbWd;
  logic        nbClearReq;
  logic        nbReady;

  int checkCount;
  int passCount;

  regfile_mp #(
    .XLEN(32), .NREGS(32), .NR(2), .NW(2), .ZERO_REG(1), .BYPASS(1)
  ) u_dut (
    .clk(clk), .rstn(rstn), .rs_addr(rsAddr), .rd_data(rdData),
    .we(we), .wa(wa), .wd(wd), .clear_req(clearReq), .ready(ready)
  );

  regfile_mp #(
    .XLEN(32), .NREGS(32), .NR(1), .NW(1), .ZERO_REG(0), .BYPASS(0)
  ) u_dut_nb (
    .clk(clk), .rstn(rstn), .rs_addr(nbRsAddr), .rd_data(nbRdData),
    .we(nbWe), .wa(nbWa), .wd(nbWd), .clear_req(nbClearReq), .ready(nbReady)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Directed test sequence.
  initial begin
    checkCount = 0;
    passCount  = 0;
    rstn       = 1'b0;
    rsAddr     = {5'd5, 5'd5};
    we         = 2'b00;
    wa         = '0;
    wd         = '0;
    clearReq   = 1'b0;
    nbRsAddr   = 5'd5;
    nbWe       = 1'b0;
    nbWa       = '0;
    nbWd       = '0;
    nbClearReq = 1'b0;

    // Reset held: outputs all zero.
    applyStimulus();
    applyStimulus();
    checkOutput("reset_ready", {31'd0, ready}, 32'd0);
    checkOutput("reset_rd0", rdData[31:0], 32'd0);
    checkOutput("reset_rd1", rdData[63:32], 32'd0);

    // Release reset: ready rises after exactly 32 edges.
    rstn = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      applyStimulus();
      if (i < 32) begin
        checkOutput("init_ready_low", {31'd0, ready}, 32'd0);
        checkOutput("init_rd_zero", rdData[31:0], 32'd0);
      end else begin
        checkOutput("init_ready_high", {31'd0, ready}, 32'd1);
        checkOutput("nb_init_ready_high", {31'd0, nbReady}, 32'd1);
      end
    end
    #1;
    checkOutput("init_reg5", rdData[31:0], 32'd0);

    // Write reg 3 with same-cycle read: bypass on main, pre-edge data on no-bypass.
    we       = 2'b01;
    wa       = {5'd0, 5'd3};
    wd       = {32'd0, 32'hDEADBEEF};
    rsAddr   = {5'd3, 5'd3};
    nbWe     = 1'b1;
    nbWa     = 5'd3;
    nbWd     = 32'hDEADBEEF;
    nbRsAddr = 5'd3;
    #1;
    checkOutput("bypass_same_cycle", rdData[31:0], 32'hDEADBEEF);
    checkOutput("bypass_port1_same", rdData[63:32], 32'hDEADBEEF);
    checkOutput("nb_same_cycle", nbRdData, 32'h0);
    applyStimulus();
    we   = 2'b00;
    nbWe = 1'b0;
    #1;
    checkOutput("bypass_next_cycle", rdData[31:0], 32'hDEADBEEF);
    checkOutput("nb_next_cycle", nbRdData, 32'hDEADBEEF);

    // Write to address 0: discarded on main, stored on the ZERO_REG=0 instance.
    we       = 2'b01;
    wa       = {5'd0, 5'd0};
    wd       = {32'd0, 32'h12345678};
    rsAddr   = {5'd3, 5'd0};
    nbWe     = 1'b1;
    nbWa     = 5'd0;
    nbWd     = 32'h12345678;
    nbRsAddr = 5'd0;
    #1;
    checkOutput("zero_same_cycle", rdData[31:0], 32'h0);
    applyStimulus();
    we   = 2'b00;
    nbWe = 1'b0;
    #1;
    checkOutput("zero_next_cycle", rdData[31:0], 32'h0);
    checkOutput("nb_zero_next_cycle", nbRdData, 32'h12345678);

    // Dual-write conflict on reg 7: port 1 wins, both bypass and storage.
    we     = 2'b11;
    wa     = {5'd7, 5'd7};
    wd     = {32'h00002222, 32'h00001111};
    rsAddr = {5'd3, 5'd7};
    #1;
    checkOutput("dual_bypass", rdData[31:0], 32'h00002222);
    checkOutput("dual_port1_indep", rdData[63:32], 32'hDEADBEEF);
    applyStimulus();
    we = 2'b00;
    #1;
    checkOutput("dual_stored", rdData[31:0], 32'h00002222);

    // Port 0 alone on reg 8 while port 1 hits reg 9: both land.
    we     = 2'b11;
    wa     = {5'd9, 5'd8};
    wd     = {32'h00009999, 32'h00008888};
    applyStimulus();
    we     = 2'b00;
    rsAddr = {5'd9, 5'd8};
    #1;
    checkOutput("split_write_p0", rdData[31:0], 32'h00008888);
    checkOutput("split_write_p1", rdData[63:32], 32'h00009999);

    // Fill regs 1..31 with nonzero patterns.
    for (int i = 1; i < 32; i++) begin
      we = 2'b01;
      wa = {5'd0, i[4:0]};
      wd = {32'd0, 32'h01010101 * i};
      applyStimulus();
    end
    we     = 2'b00;
    rsAddr = {5'd4, 5'd31};
    #1;
    checkOutput("fill_reg31", rdData[31:0], 32'h1F1F1F1F);
    checkOutput("fill_reg4", rdData[63:32], 32'h04040404);

    // Clear request with a simultaneous write to reg 4.
    clearReq = 1'b1;
    we       = 2'b01;
    wa       = {5'd0, 5'd4};
    wd       = {32'd0, 32'h000000AA};
    rsAddr   = {5'd31, 5'd4};
    #1;
    checkOutput("clrreq_bypass", rdData[31:0], 32'h000000AA);
    checkOutput("clrreq_ready", {31'd0, ready}, 32'd1);
    applyStimulus();
    clearReq = 1'b0;
    we       = 2'b11;
    wa       = {5'd9, 5'd9};
    wd       = {32'h00005555, 32'h00005555};
    rsAddr   = {5'd9, 5'd4};
    #1;
    checkOutput("clr_ready_low", {31'd0, ready}, 32'd0);
    checkOutput("clr_rd_zero", rdData[31:0], 32'd0);
    for (int i = 1; i <= 32; i++) begin
      applyStimulus();
      if (i < 32) begin
        checkOutput("clr_ready_low_loop", {31'd0, ready}, 32'd0);
      end else begin
        checkOutput("clr_ready_high", {31'd0, ready}, 32'd1);
      end
      clearReq = (i == 10);
    end
    clearReq = 1'b0;
    we       = 2'b00;
    for (int r = 0; r < 32; r++) begin
      rsAddr = {5'(31 - r), 5'(r)};
      #1;
      checkOutput("post_clr_p0", rdData[31:0], 32'd0);
      checkOutput("post_clr_p1", rdData[63:32], 32'd0);
    end

    // Populate regs 12 and 20, then abort a clear at clr_cnt=10 with reset.
    applyStimulus();
    we = 2'b01;
    wa = {5'd0, 5'd12};
    wd = {32'd0, 32'h0000CAFE};
    applyStimulus();
    wa = {5'd0, 5'd20};
    wd = {32'd0, 32'h0000BEEF};
    applyStimulus();
    we     = 2'b00;
    rsAddr = {5'd20, 5'd12};
    #1;
    checkOutput("pre_abort_reg12", rdData[31:0], 32'h0000CAFE);
    checkOutput("pre_abort_reg20", rdData[63:32], 32'h0000BEEF);
    clearReq = 1'b1;
    applyStimulus();
    clearReq = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
    end
    rstn = 1'b0;
    #1;
    checkOutput("abort_ready", {31'd0, ready}, 32'd0);
    checkOutput("abort_rd0", rdData[31:0], 32'd0);
    checkOutput("abort_rd1", rdData[63:32], 32'd0);
    applyStimulus();
    applyStimulus();
    rstn = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      applyStimulus();
      if (i < 32) begin
        checkOutput("abort_ready_low_loop", {31'd0, ready}, 32'd0);
      end else begin
        checkOutput("abort_ready_high", {31'd0, ready}, 32'd1);
      end
    end
    #1;
    checkOutput("abort_reg12", rdData[31:0], 32'd0);
    checkOutput("abort_reg20", rdData[63:32], 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file. Next generation of the core's 2R/1W register file.
- Generalised in data width, depth, read-port count and write-port count.
- Adds same-cycle write-to-read bypass, deterministic multi-write priority, and a sequential clear engine that zeroes storage after reset or on request.
- Sits between decode (read addresses) and writeback (write ports) in the pipeline.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of two, >=2).
- AW, $clog2(NREGS), register address width (derived, not overridden).
- NR, 2, number of read ports (>=1).
- NW, 1, number of write ports (>=1).
- ZERO_REG, 1, 1 = register 0 hardwired to zero.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rstn  input  1  reset, asynchronous assert, active-low.
- rs_addr  input  NR*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data  output  NR*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- we  input  NW  write enable, one bit per write port.
- wa  input  NW*AW  write addresses; port j uses bits [j*AW +: AW].
- wd  input  NW*XLEN  write data; port j uses bits [j*XLEN +: XLEN].
- clear_req  input  1  one-cycle pulse; requests a full re-clear of storage.
- ready  output  1  1 = storage valid, writes accepted, reads live.

Behaviour:
- Reset: rstn=0 asynchronously forces state=CLEAR, clr_cnt=0, ready=0.
  - Storage array is not reset directly; it is zeroed by the clear engine.
  - rd_data reads 0 whenever ready=0, so all outputs are 0 during reset.
- FSM states: CLEAR, READY.
  - CLEAR: each posedge writes 0 to entry clr_cnt, then clr_cnt increments.
  - On the posedge that clears entry NREGS-1: state becomes READY, ready=1, clr_cnt=0.
  - First cleared entry is entry 0, on the first posedge with rstn=1.
  - ready rises after exactly NREGS posedges following reset release (32 for defaults).
  - READY: a clear_req=1 sampled at posedge moves state to CLEAR with clr_cnt=0; ready=0 from the next cycle.
  - Any write sampled on that same edge is still performed.
  - clear_req during CLEAR is ignored; the count does not restart.
  - Reset asserted mid-clear aborts it immediately; the full sequence restarts after release.
- Writes:
  - Performed only in READY, at posedge, for each j with we[j]=1.
  - we is ignored entirely during CLEAR.
  - Same address on several enabled ports: the highest-index port wins.
  - ZERO_REG=1: writes to address 0 are discarded and entry 0 always reads 0.
- Reads:
  - Combinational, zero latency; rd_data[k] = storage[rs_addr[k]] when ready=1.
  - BYPASS=1 and ready=1: if any enabled write port targets rs_addr[k] this cycle, rd_data[k] = wd of the highest-index matching port instead of storage.
  - With ZERO_REG=1, address 0 is never bypassed.
  - BYPASS=0: reads return pre-edge storage; new data is visible the cycle after the write.
  - All read ports are independent; any number may use the same address.
- Address range: AW covers exactly NREGS, so there are no out-of-range addresses.
- Storage is a plain array; the clear engine and the write ports are merged in one sequential process, with the clear engine having priority during CLEAR.

Test Plan:
- Reset, then count: release rstn; hold rs_addr=5 on all ports -> ready=0 and rd_data=0 for 32 cycles; ready=1 on cycle 32; read of reg 5 = 0x00000000.
- Write, then read with bypass: we[0]=1, wa=3, wd=0xDEADBEEF, rs_addr[0]=3 in the same cycle -> rd_data[0]=0xDEADBEEF combinationally; next cycle, with no write, still 0xDEADBEEF. With BYPASS=0, the same-cycle read returns 0x0.
- Zero register: write 0x12345678 to address 0 -> rd_data=0 on the same and the next cycle. With ZERO_REG=0, the next-cycle read returns 0x12345678.
- Dual-write conflict (NW=2): we=2'b11, wa0=wa1=7, wd0=0x1111, wd1=0x2222 -> reg 7 = 0x2222, and the same-cycle bypassed read = 0x2222.
- Clear request: fill regs 1..31 with nonzero values, pulse clear_req with a simultaneous write of 0xAA to reg 4 -> write lands, then ready=0 for 32 cycles; afterwards all regs read 0; we asserted during CLEAR has no effect.
- Reset mid-clear: assert rstn=0 at clr_cnt=10 -> ready=0 and rd_data=0 immediately; after release, ready returns exactly 32 cycles later and all regs read 0.
